// File: rtl/count_capture_if.sv
// Capture-port bundle for count_capture: counter input, event strobe,
// overflow clear and the show-ahead FIFO read side.
interface count_capture_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] Q;
    logic             Event;
    logic             Clear_ovf;
    logic             Ready;
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic [LW-1:0]    Level;
    logic             Overflow;

    modport master (
        output Q, Event, Clear_ovf, Ready,
        input  Data, Valid, Level, Overflow
    );

    modport slave (
        input  Q, Event, Clear_ovf, Ready,
        output Data, Valid, Level, Overflow
    );
endinterface

// File: rtl/count_capture.sv
// Captures the running counter on each rising Event into a small
// show-ahead FIFO with a sticky overflow flag for dropped captures.
module count_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic CLK,
    input  logic Reset,
    count_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ev_d_q;
    logic             ovf_q, ovf_d;

    logic valid, full, rise, pop, push, drop;

    assign valid = (level_q != '0);
    assign full  = (level_q == LW'(DEPTH));
    assign rise  = bus.Event & ~ev_d_q;
    assign pop   = valid & bus.Ready;
    // A full FIFO still accepts when the head leaves on the same edge
    assign push  = rise & (~full | pop);
    assign drop  = rise & ~push;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !push)
            level_d = level_q - 1'b1;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (bus.Clear_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ev_d_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ev_d_q  <= bus.Event;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: Data is gated by Valid
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.Q;
    end

    assign bus.Data     = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.Valid    = valid;
    assign bus.Level    = level_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_count_capture.sv
// Randomized and directed checks of count_capture against a queue-based
// reference model of the capture FIFO.
module tb_count_capture;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic Reset;

    count_capture_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    int mq[$];
    bit m_ovf;
    bit m_evd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_evd = 1'b1;
    endtask

    task automatic chk_outs();
        chk("level", 32'(bus.Level), 32'(mq.size()));
        chk("valid", 32'(bus.Valid), 32'(mq.size() != 0));
        chk("data", 32'(bus.Data), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
        chk("ovf", 32'(bus.Overflow), 32'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then check
    task automatic step(input int q, input bit ev, input bit clr,
                        input bit rdy);
        bit rise, pop, push;
        bus.Q         = WIDTH'(q);
        bus.Event     = ev;
        bus.Clear_ovf = clr;
        bus.Ready     = rdy;
        @(posedge CLK);
        rise = ev && !m_evd;
        pop  = (mq.size() != 0) && rdy;
        push = rise && ((mq.size() < DEPTH) || pop);
        if (pop)
            void'(mq.pop_front());
        if (push)
            mq.push_back(q & ((1 << WIDTH) - 1));
        if (rise && !push)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        m_evd = ev;
        #1;
        chk_outs();
    endtask

    task automatic pulse(input int q, input bit rdy);
        step(q, 1'b1, 1'b0, rdy);
        step(q, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int v;
        bus.Q = '0;
        bus.Event = 1'b1;
        bus.Clear_ovf = 1'b0;
        bus.Ready = 1'b0;
        Reset = 1'b1;
        model_reset();
        #12;
        chk_outs();
        Reset = 1'b0;
        @(negedge CLK);

        // Single capture then drain
        step(0, 0, 0, 0);
        step(8'h2A, 1, 0, 0);
        chk("single_data", 32'(bus.Data), 32'h2A);
        step(0, 0, 0, 1);
        chk("single_empty", 32'(bus.Valid), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++)
            pulse(i, 0);
        chk("fill_ovf", 32'(bus.Overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("fill_order", 32'(bus.Data), 32'(i));
            step(0, 0, 0, 1);
        end
        chk("fill_drained", 32'(bus.Level), 32'd0);
        step(0, 0, 1, 0);

        // Full with simultaneous pop
        for (int i = 10; i <= 13; i++)
            pulse(i, 0);
        step(14, 1, 0, 1);
        chk("full_pop_lvl", 32'(bus.Level), 32'd4);
        chk("full_pop_ovf", 32'(bus.Overflow), 32'd0);
        for (int i = 11; i <= 14; i++) begin
            chk("full_pop_order", 32'(bus.Data), 32'(i));
            step(0, 0, 0, 1);
        end

        // Held Event across Q wrap, then pointer wrap
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step((8'hFE + i) & 8'hFF, 1, 0, 0);
        chk("held_lvl", 32'(bus.Level), 32'd1);
        chk("held_data", 32'(bus.Data), 32'hFE);
        step(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(8'h40 + i, 1, 0, 1);
            step(0, 0, 0, 0);
        end
        chk("wrap_data", 32'(bus.Data), 32'h48);

        // Overflow clear priority
        for (int i = 0; i < 4; i++)
            pulse(i, 0);
        step(7, 1, 1, 0);
        chk("clr_vs_drop", 32'(bus.Overflow), 32'd1);
        step(7, 0, 1, 0);
        chk("clr_alone", 32'(bus.Overflow), 32'd0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1);

        // Reset mid-stream with Event held high
        pulse(1, 0);
        pulse(2, 0);
        step(3, 1, 0, 0);
        step(4, 1, 0, 0);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_outs();
        #1 Reset = 1'b0;
        step(5, 1, 0, 0);
        step(6, 1, 0, 0);
        chk("rst_no_cap", 32'(bus.Level), 32'd0);
        step(7, 0, 0, 0);
        step(8, 1, 0, 0);
        chk("rst_recap", 32'(bus.Data), 32'd8);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            v = int'($urandom_range(0, 255));
            step(v, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the captured count width (matches the 8-bit T flip-flop counter).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving capture FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port Q  input  WIDTH  the running counter value from the upstream counter.
REQ-006 The block SHALL have port Event  input  1  the capture request, synchronous to CLK, acting on its rising edge.
REQ-007 The block SHALL have port Clear_ovf  input  1  clears the sticky overflow flag.
REQ-008 The block SHALL have port Ready  input  1  the consumer accepts the head entry.
REQ-009 The block SHALL have port Data  output  WIDTH  the head-of-FIFO captured value.
REQ-010 The block SHALL have port Valid  output  1  meaning Data holds an unread capture.
REQ-011 The block SHALL have port Level  output  clog2(DEPTH)+1  the current FIFO occupancy.
REQ-012 The block SHALL have port Overflow  output  1  a sticky flag set when a capture was dropped.

Function
REQ-013 The block SHALL register Event each cycle as Event_d; edge = Event & !Event_d, evaluated at each rising CLK edge.
REQ-014 On an edge, the block SHALL push the Q value sampled at that same CLK edge into the FIFO, subject to REQ-017.
REQ-015 Capture latency SHALL be one edge: Valid and Data reflect a push into an empty FIFO immediately after the capturing edge.
REQ-016 The FIFO SHALL be show-ahead: Data = oldest entry while Valid=1; Data = 0 while empty; Valid = (Level != 0).
REQ-017 A push SHALL be accepted if Level < DEPTH, or if Level = DEPTH and a pop occurs in the same cycle.
REQ-018 A pop SHALL occur on a CLK edge where Valid & Ready; Ready while Valid=0 SHALL be ignored.
REQ-019 Simultaneous push and pop SHALL leave Level unchanged, pop the old head and append the new value in order.
REQ-020 Level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH with no loss or reordering across the wrap.
REQ-022 An edge rejected by REQ-017 SHALL be dropped (FIFO contents unchanged) and SHALL set Overflow on that edge.
REQ-023 Overflow SHALL remain 1 until a CLK edge with Clear_ovf=1 and no simultaneous drop; set SHALL win over clear.
REQ-024 Event held high for multiple cycles SHALL produce exactly one capture; a new capture requires Event to return low first.
REQ-025 Q SHALL be captured verbatim, including wrap from 2^WIDTH-1 to 0; the block performs no arithmetic on Q.

Reset
REQ-026 While Reset=1, the block SHALL hold Data=0, Valid=0, Level=0, Overflow=0, and both pointers at 0, independent of CLK.
REQ-027 Reset SHALL set Event_d=1, so an Event held high through reset release produces no capture until it falls and rises again.
REQ-028 Reset asserted mid-operation SHALL discard all stored captures and any in-flight push or pop of that cycle.
REQ-029 The first edge after Reset falls SHALL operate normally, with no extra idle cycle.

Verification
REQ-030 Single capture: Q=8'h2A, one-cycle Event pulse, Ready=0 -> next cycle Valid=1, Data=8'h2A, Level=1; then Ready=1 for one edge -> Valid=0, Data=0, Level=0.
REQ-031 Fill and overflow: Ready=0, five Event pulses at Q=1,2,3,4,5 -> Level=4, Overflow=1, pops yield 1,2,3,4 in order and 5 is absent.
REQ-032 Full with simultaneous pop: Level=4 holding 10,11,12,13; edge with Q=14 and Ready=1 -> Level=4, Overflow stays 0, pops yield 11,12,13,14.
REQ-033 Held Event and wrap: Event high 6 cycles while Q runs 8'hFE,FF,00,... -> exactly one capture of 8'hFE; pointer wrap after 9 push/pop pairs preserves order.
REQ-034 Overflow clear priority: Overflow=1, Clear_ovf=1 on the same edge as a dropped capture -> Overflow=1; Clear_ovf=1 with no drop -> Overflow=0.
REQ-035 Reset mid-stream: Level=3, Event held high, Reset pulsed asynchronously between edges -> outputs 0 immediately; no capture until Event falls and rises again.
